// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared floating-point datapath constants and types
package fp_pkg;

  localparam int FP_W           = 32;
  localparam int FP_ADD_LATENCY = 3;
  localparam int FP_SIGN_W      = 1;
  localparam int FP_EXP_W       = 8;
  localparam int FP_MANT_W      = 23;

  typedef struct packed {
    logic                 sign;
    logic [FP_EXP_W-1:0]  exp;
    logic [FP_MANT_W-1:0] mant;
  } fp_word_t;

endpackage

// File: rtl/fp_valid_delay.sv
// rtl/fp_valid_delay.sv - {valid, tag} shift register mirroring the fp_adder pipeline depth
module fp_valid_delay
  import fp_pkg::*;
#(
  parameter int LATENCY = FP_ADD_LATENCY,
  parameter int TAG_W   = 4,
  parameter int CNT_W   = $clog2(LATENCY + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             valid_o,
  output logic [TAG_W-1:0] tag_o,
  output logic [CNT_W-1:0] inflight_o
);

  logic [LATENCY-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q [LATENCY];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < LATENCY; i++) tag_q[i] <= '0;
    end else begin
      valid_q[0] <= valid_i;
      tag_q[0]   <= tag_i;
      for (int i = 1; i < LATENCY; i++) begin
        valid_q[i] <= valid_q[i-1];
        tag_q[i]   <= tag_q[i-1];
      end
    end
  end

  always_comb begin
    inflight_o = '0;
    for (int i = 0; i < LATENCY; i++) inflight_o = inflight_o + CNT_W'(valid_q[i]);
  end

  assign valid_o = valid_q[LATENCY-1];
  assign tag_o   = tag_q[LATENCY-1];

endmodule

// File: rtl/fp_result_buffer.sv
// rtl/fp_result_buffer.sv - credit-gated result FIFO behind the un-stallable fp_adder
module fp_result_buffer
  import fp_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int LATENCY = FP_ADD_LATENCY,
  parameter int TAG_W   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [TAG_W-1:0]         in_tag,
  input  logic [FP_W-1:0]          add_result,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [FP_W-1:0]          out_result,
  output logic [TAG_W-1:0]         out_tag,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam int INF_W = $clog2(LATENCY + 1);
  localparam int SUM_W = ((OCC_W > INF_W) ? OCC_W : INF_W) + 1;

  logic             accept, pop, wr_en;
  logic [TAG_W-1:0] wr_tag;
  logic [INF_W-1:0] inflight;
  logic [SUM_W-1:0] credit_used;

  logic [FP_W-1:0]  res_mem [DEPTH];
  logic [TAG_W-1:0] tag_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;

  fp_valid_delay #(
    .LATENCY (LATENCY),
    .TAG_W   (TAG_W),
    .CNT_W   (INF_W)
  ) u_delay (
    .clk        (clk),
    .rst        (rst),
    .valid_i    (accept),
    .tag_i      (in_tag),
    .valid_o    (wr_en),
    .tag_o      (wr_tag),
    .inflight_o (inflight)
  );

  // Credit counts both stored and in-flight results; a pop only frees credit next cycle.
  assign credit_used = SUM_W'(occ_q) + SUM_W'(inflight);
  assign in_ready    = credit_used < SUM_W'(DEPTH);
  assign accept      = in_valid & in_ready;
  assign out_valid   = (occ_q != '0);
  assign pop         = out_valid & out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(wr_en);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    occ_d    = occ_q + OCC_W'(wr_en) - OCC_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      res_mem[wr_ptr_q] <= add_result;
      tag_mem[wr_ptr_q] <= wr_tag;
    end
  end

  // Storage is not cleared on reset, so the head is masked while the FIFO is empty.
  assign out_result = out_valid ? res_mem[rd_ptr_q] : '0;
  assign out_tag    = out_valid ? tag_mem[rd_ptr_q] : '0;
  assign occupancy  = occ_q;

  wr_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(wr_en && (occ_q == OCC_W'(DEPTH))));

endmodule

// File: doc/fp_result_buffer.md
Name: fp_result_buffer

Overview:
- Downstream companion of the 3-stage fp_adder pipeline; the adder has no valid signalling.
- Tracks which issued operand pairs are in flight through a LATENCY-deep valid/tag delay line.
- Captures the adder's registered result into a DEPTH-entry FIFO when the matching valid emerges, and presents results on a valid/ready stream.
- Issues credit-based in_ready so the un-stallable adder can never overflow the FIFO.

Parameters:
- DEPTH, 8, FIFO entries; power of two; must be >= LATENCY+1 for full throughput.
- LATENCY, 3, clock edges from a/b applied at fp_adder input to result valid at fp_adder output.
- TAG_W, 4, width of the sideband tag carried alongside each operation.

Ports:
- clk  in  1  rising-edge clock, shared with fp_adder.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  issuer is driving a/b into fp_adder this cycle.
- in_ready  out  1  buffer guarantees space for a result if issued this cycle.
- in_tag  in  TAG_W  sideband tag for the issued operation.
- add_result  in  32  fp_adder result register output.
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  consumer accepts the head this cycle.
- out_result  out  32  FIFO head result.
- out_tag  out  TAG_W  FIFO head tag.
- occupancy  out  $clog2(DEPTH)+1  entries stored in the FIFO (excludes in-flight operations).

Behaviour:
- accept = in_valid & in_ready.
  - The issuer must hold a/b stable only in the accept cycle.
  - in_valid without in_ready: the operation is not tracked; the issuer must not rely on its result.
- Delay line:
  - LATENCY stages of {valid, tag}; stage 0 loads {accept, in_tag} each edge.
  - The last stage, when valid, generates a write.
  - Write timing: accept in cycle 0 => add_result sampled and written at the edge ending cycle LATENCY; out_valid earliest in cycle LATENCY+1.
- inflight = number of valid bits in the delay line (registered-state count).
- in_ready = (occupancy + inflight) < DEPTH.
  - Combinational from registered state only; no same-cycle pop bypass.
  - A pop frees credit from the next cycle.
- FIFO:
  - pop = out_valid & out_ready.
  - Write and pop on the same edge are both performed; occupancy is unchanged.
  - Write to a full FIFO is impossible by the credit rule; assert an error in simulation if it occurs.
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - out_result/out_tag are driven from the head entry and hold stable while out_valid & !out_ready.
- Reset (rst=1 at a clock edge):
  - Delay line cleared; in-flight operations are discarded.
  - FIFO emptied (pointers 0, occupancy 0).
  - out_valid=0, in_ready=1, out_result=0, out_tag=0.
  - Reset asserted mid-operation behaves identically.
  - Results emerging from fp_adder after reset are ignored (their valids were cleared).
- No arithmetic on result data; values pass through bit-exact.

Decomposition:
- Shared package fp_pkg:
  - FP_W=32.
  - FP_ADD_LATENCY=3 (default for LATENCY).
  - Field widths SIGN/EXP=8/MANT=23 for future stages.
- Sub-module fp_valid_delay: parameterised {valid, tag} shift register with inflight count output.

Test Plan:
- Single op: accept a=0x3F800000, b=0x40000000, tag=5 at cycle 0 -> out_valid first high cycle 4 with out_result=0x40400000, out_tag=5; occupancy 1 then 0 after pop.
- Back-pressure: out_ready=0, in_valid=1 continuously -> exactly 8 accepts (cycles 0-7), in_ready low from cycle 8; occupancy reaches 8 at cycle 11; no writes lost.
- Full throughput: out_ready=1, 20 back-to-back accepts tags 0..15,0..3 -> in_ready never drops; outputs in order, one per cycle, cycles 4..23.
- Full + simultaneous: FIFO at 8, assert out_ready one cycle -> one pop; in_ready high the following cycle only; next accept's result lands without overflow.
- Reset mid-flight: 3 ops in flight, 2 stored, rst at cycle N -> cycle N+1: out_valid=0, occupancy=0, in_ready=1; no stale result appears in the next 5 cycles.
- Wrap-around: 3×DEPTH+3 ops with random out_ready -> output sequence equals input tag order; error assertion never fires.
